// File: rtl/riscv_bus_pkg.sv
// Types and constants shared by the core-side memory bus fabrics.
package riscv_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } bus_state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

    // Index width for `value` items, never below 1 so single-entry vectors stay legal.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: maps a core byte address onto a slave window.
module bus_addr_decode #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_SLAVES = 4,
    parameter int                    WIN_BITS   = 8,
    parameter int                    IDX_W      = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h1001_0000)
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  hit_o,
    output logic                  misaligned_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic [WIN_BITS-1:0]   offset_o
);

    localparam int BYTES = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] idx_full;

    assign off      = addr_i - BASE_ADDR;
    assign idx_full = off >> WIN_BITS;

    // The lower-bound compare guards the subtraction, so a wrapped offset never hits.
    assign hit_o        = (addr_i >= BASE_ADDR) && (idx_full < ADDR_WIDTH'(NUM_SLAVES));
    assign misaligned_o = (addr_i & ADDR_WIDTH'(BYTES - 1)) != '0;
    assign idx_o        = idx_full[IDX_W-1:0];
    assign offset_o     = off[WIN_BITS-1:0];

endmodule

// File: rtl/mem_bus_fabric.sv
// Core load/store port fanned out to NUM_SLAVES ready-handshake slaves with
// decode/alignment errors and an access timeout.
module mem_bus_fabric #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_SLAVES = 4,
    parameter int                    WIN_BITS   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(riscv_bus_pkg::DEFAULT_BASE_ADDR),
    parameter int                    TIMEOUT    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             m_req,
    input  logic                             m_we,
    input  logic [ADDR_WIDTH-1:0]            m_addr,
    input  logic [DATA_WIDTH-1:0]            m_wdata,
    output logic                             m_ack,
    output logic                             m_err,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             m_busy,
    output logic [NUM_SLAVES-1:0]            s_sel,
    output logic                             s_we,
    output logic [WIN_BITS-1:0]              s_addr,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]            s_ready
);

    import riscv_bus_pkg::*;

    localparam int IDX_W = clog2_min1(NUM_SLAVES);
    localparam int CNT_W = clog2_min1(TIMEOUT + 1);

    bus_state_e            state_q;
    logic [NUM_SLAVES-1:0] sel_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  we_q;
    logic [WIN_BITS-1:0]   addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  ack_q;
    logic                  err_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  dec_hit;
    logic                  dec_mis;
    logic [IDX_W-1:0]      dec_idx;
    logic [WIN_BITS-1:0]   dec_off;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  ready_hit;

    bus_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .WIN_BITS   (WIN_BITS),
        .IDX_W      (IDX_W),
        .BASE_ADDR  (BASE_ADDR)
    ) u_decode (
        .addr_i       (m_addr),
        .hit_o        (dec_hit),
        .misaligned_o (dec_mis),
        .idx_o        (dec_idx),
        .offset_o     (dec_off)
    );

    // NOTE: default assignment first so no path leaves sel_rdata unassigned (no latch).
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) sel_rdata = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign ready_hit = |(s_ready & sel_q);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m_req) begin
                        busy_q <= 1'b1;
                        if (!dec_hit || dec_mis) begin
                            state_q <= ST_RESP;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state_q <= ST_ACCESS;
                            sel_q   <= NUM_SLAVES'(1) << dec_idx;
                            idx_q   <= dec_idx;
                            we_q    <= m_we;
                            addr_q  <= dec_off;
                            wdata_q <= m_wdata;
                            cnt_q   <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Ready is tested first so it wins over a timeout in the same cycle.
                    if (ready_hit || cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q <= ST_RESP;
                        ack_q   <= 1'b1;
                        err_q   <= !ready_hit;
                        rdata_q <= (ready_hit && !we_q) ? sel_rdata : '0;
                        sel_q   <= '0;
                        we_q    <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_ack   = ack_q;
    assign m_err   = err_q;
    assign m_rdata = rdata_q;
    assign m_busy  = busy_q;
    assign s_sel   = sel_q;
    assign s_we    = we_q;
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Directed bench for mem_bus_fabric with a slave model whose ready delay is programmable.
module tb_mem_bus_fabric;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         m_req = 1'b0;
    logic         m_we = 1'b0;
    logic [31:0]  m_addr = '0;
    logic [31:0]  m_wdata = '0;
    logic         m_ack;
    logic         m_err;
    logic [31:0]  m_rdata;
    logic         m_busy;
    logic [3:0]   s_sel;
    logic         s_we;
    logic [7:0]   s_addr;
    logic [31:0]  s_wdata;
    logic [127:0] s_rdata;
    logic [3:0]   s_ready = '0;

    int checks = 0;
    int failures = 0;

    int         ready_delay = 0;
    int         slave_cnt = 0;
    logic [3:0] noise_ready = '0;

    int          lat;
    int          sel_cycles;
    logic [3:0]  sel_or;
    logic        ack_err;
    logic [31:0] ack_rdata;
    logic        stable_ok;
    logic        got;
    int          extra_acks;

    assign s_rdata = {32'h3333_3333, 32'hCAFE_0002, 32'hDEAD_BEEF, 32'h0000_1111};

    mem_bus_fabric dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .m_rdata (m_rdata),
        .m_busy  (m_busy),
        .s_sel   (s_sel),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ready (s_ready)
    );

    always #5 clk = ~clk;

    // Selected slave raises ready in its (ready_delay+1)-th selected cycle; noise_ready models unselected slaves.
    always @(negedge clk) begin
        if (|s_sel) begin
            s_ready = ((slave_cnt == ready_delay) ? s_sel : 4'b0000) | noise_ready;
            slave_cnt++;
        end else begin
            s_ready = noise_ready;
            slave_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
        end
    endtask

    // Issues one request at a negedge, watches the slave side until m_ack, then returns in IDLE.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int delay);
        m_we = we; m_addr = addr; m_wdata = wdata; ready_delay = delay; m_req = 1'b1;
        lat = 0; sel_or = '0; sel_cycles = 0; stable_ok = 1'b1; got = 1'b0;
        ack_err = 1'b0; ack_rdata = '0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            m_req = 1'b0;
            if (|s_sel) begin
                sel_or |= s_sel;
                sel_cycles++;
                if (s_we !== we || s_wdata !== wdata || s_addr !== addr[7:0]) stable_ok = 1'b0;
            end
            if (m_ack) begin
                got = 1'b1; ack_err = m_err; ack_rdata = m_rdata;
            end
        end
        if (!got) check("ack_wait_expired", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ack", m_ack, 0);
        check("rst_err", m_err, 0);
        check("rst_rdata", m_rdata, 0);
        check("rst_busy", m_busy, 0);
        check("rst_sel", s_sel, 0);
        check("rst_swe", s_we, 0);
        rst = 1'b0;
        @(negedge clk);

        // Read slave 1, ready at once
        do_access(1'b0, 32'h1001_0104, 32'h0, 0);
        check("t1_lat", lat, 2);
        check("t1_sel", sel_or, 4'b0010);
        check("t1_sel_cycles", sel_cycles, 1);
        check("t1_stable", stable_ok, 1);
        check("t1_err", ack_err, 0);
        check("t1_rdata", ack_rdata, 32'hDEAD_BEEF);
        check("t1_ack_pulse", m_ack, 0);
        check("t1_rdata_idle", m_rdata, 0);

        // Write slave 3, ready after 5 cycles
        do_access(1'b1, 32'h1001_0300, 32'h0000_00A5, 5);
        check("t2_lat", lat, 7);
        check("t2_sel", sel_or, 4'b1000);
        check("t2_sel_cycles", sel_cycles, 6);
        check("t2_stable", stable_ok, 1);
        check("t2_err", ack_err, 0);
        check("t2_rdata", ack_rdata, 0);

        // Decode misses: past last window and below base
        do_access(1'b0, 32'h1001_0400, 32'h0, 0);
        check("t3a_lat", lat, 1);
        check("t3a_sel", sel_or, 0);
        check("t3a_err", ack_err, 1);
        check("t3a_rdata", ack_rdata, 0);
        do_access(1'b0, 32'h1000_FFFC, 32'h0, 0);
        check("t3b_lat", lat, 1);
        check("t3b_sel", sel_or, 0);
        check("t3b_err", ack_err, 1);

        // Misaligned
        do_access(1'b0, 32'h1001_0002, 32'h0, 0);
        check("t4_lat", lat, 1);
        check("t4_sel", sel_or, 0);
        check("t4_err", ack_err, 1);

        // Slave 2 never ready while other slaves assert ready: timeout
        noise_ready = 4'b1011;
        do_access(1'b0, 32'h1001_0208, 32'h0, 1000);
        check("t5a_sel_cycles", sel_cycles, 16);
        check("t5a_lat", lat, 17);
        check("t5a_sel", sel_or, 4'b0100);
        check("t5a_err", ack_err, 1);
        check("t5a_rdata", ack_rdata, 0);
        noise_ready = 4'b0000;

        // Ready in the 16th cycle wins over the timeout
        do_access(1'b0, 32'h1001_0208, 32'h0, 15);
        check("t5b_sel_cycles", sel_cycles, 16);
        check("t5b_err", ack_err, 0);
        check("t5b_rdata", ack_rdata, 32'hCAFE_0002);

        // Request held high while busy must not start a second access
        m_we = 1'b0; m_addr = 32'h1001_0104; m_wdata = '0; ready_delay = 3; m_req = 1'b1;
        @(negedge clk);
        check("t6a_busy", m_busy, 1);
        check("t6a_sel0", s_sel, 4'b0010);
        m_addr = 32'h1001_0000;
        lat = 1; got = 1'b0; sel_or = s_sel; stable_ok = 1'b1;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            sel_or |= s_sel;
            if (|s_sel && s_addr !== 8'h04) stable_ok = 1'b0;
            if (m_ack) got = 1'b1;
        end
        m_req = 1'b0;
        check("t6a_lat", lat, 5);
        check("t6a_sel", sel_or, 4'b0010);
        check("t6a_addr_stable", stable_ok, 1);
        extra_acks = 0; sel_or = '0;
        repeat (3) begin
            @(negedge clk);
            if (m_ack) extra_acks++;
            sel_or |= s_sel;
        end
        check("t6a_no_second_ack", extra_acks, 0);
        check("t6a_no_second_sel", sel_or, 0);

        // Reset in the middle of a write access
        m_we = 1'b1; m_addr = 32'h1001_0210; m_wdata = 32'h1234_5678; ready_delay = 1000; m_req = 1'b1;
        @(negedge clk);
        m_req = 1'b0;
        @(negedge clk);
        check("t6b_pre_sel", s_sel, 4'b0100);
        check("t6b_pre_swe", s_we, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6b_sel", s_sel, 0);
        check("t6b_swe", s_we, 0);
        check("t6b_saddr", s_addr, 0);
        check("t6b_swdata", s_wdata, 0);
        check("t6b_busy", m_busy, 0);
        check("t6b_ack", m_ack, 0);
        check("t6b_err", m_err, 0);
        check("t6b_rdata", m_rdata, 0);
        rst = 1'b0;
        extra_acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (m_ack) extra_acks++;
        end
        check("t6b_no_ack", extra_acks, 0);

        // Normal access after reset recovery
        do_access(1'b0, 32'h1001_0010, 32'h0, 0);
        check("t7_lat", lat, 2);
        check("t7_sel", sel_or, 4'b0001);
        check("t7_err", ack_err, 0);
        check("t7_rdata", ack_rdata, 32'h0000_1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
